hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core (F, D, E, M, W). Every cycle it produces the stall and flush controls for all pipeline registers from the busy, hazard and redirect conditions. It runs a small state machine that serializes CSR instructions: the pipeline drains before a CSR is read, and nothing younger issues until that CSR retires. It also tracks an in-flight instruction fetch that became stale because of a redirect or trap.

---
 rtl/hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencing for the five-stage core.
// Serializes CSR instructions (drain before read, hold younger work until
// the CSR retires) and tracks an in-flight fetch made stale by a redirect.
module hazard_ctrl #(
    parameter int unsigned POST_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_busy,
    input  logic       d_busy,
    input  logic       ex_busy,
    input  logic       redirect,
    input  logic       trap,
    input  logic       d_valid,
    input  logic       d_is_csr,
    input  logic       d_use1,
    input  logic       d_use2,
    input  logic [4:0] d_ra1,
    input  logic [4:0] d_ra2,
    input  logic       e_valid,
    input  logic       e_is_load,
    input  logic [4:0] e_rd,
    input  logic       m_valid,
    input  logic       w_valid,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       stall_m,
    output logic       flush_d,
    output logic       flush_e,
    output logic       flush_m,
    output logic       flush_w,
    output logic       discard_fetch,
    output logic       serializing
);

    localparam int unsigned CNT_W = 2;
    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_POST  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_disc_pend;
    logic               w_disc_pend_nxt;

    logic               w_pipe_occ;
    logic               w_csr_in_d;
    logic               w_load_use;
    logic               w_redirect_eff;
    logic               w_disc_set;

    // Occupancy and hazard qualifiers shared by the priority chain.
    always_comb begin
        w_pipe_occ     = e_valid | m_valid | w_valid;
        w_csr_in_d     = d_valid & d_is_csr;
        w_load_use     = d_valid & e_valid & e_is_load & (e_rd != REG_W'(0)) &
                         ((d_use1 & (d_ra1 == e_rd)) | (d_use2 & (d_ra2 == e_rd)));
        w_redirect_eff = redirect & ~d_busy & ~ex_busy;
        w_disc_set     = (trap | w_redirect_eff) & i_busy;
    end

    // Stale-fetch flag: set on a redirect/trap with a fetch in flight,
    // cleared when that fetch finally returns.
    always_comb begin
        w_disc_pend_nxt = w_disc_set | (r_disc_pend & i_busy);
    end

    // State register, POST counter and stale-fetch flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_cnt       <= CNT_W'(0);
            r_disc_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_disc_pend <= w_disc_pend_nxt;
        end
    end

    // Priority-ordered next-state and stall/flush decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_m     = 1'b0;
        flush_w     = 1'b0;

        if (trap) begin
            // F reloads with the trap vector, so it is never held here.
            stall_f     = 1'b0;
            flush_d     = 1'b1;
            flush_e     = 1'b1;
            flush_m     = 1'b1;
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = CNT_W'(0);
        end else if (d_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (ex_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (redirect) begin
            // F reloads with the target PC; a CSR waiting in D is killed.
            stall_f = 1'b0;
            flush_d = 1'b1;
            flush_e = 1'b1;
            if (r_state == ST_DRAIN) begin
                w_state_nxt = ST_RUN;
            end
        end else if (r_state == ST_POST) begin
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            flush_e   = 1'b1;
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                w_state_nxt = ST_RUN;
            end
        end else if (r_state == ST_DRAIN) begin
            if (w_pipe_occ) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end else begin
                w_state_nxt = ST_POST;
                w_cnt_nxt   = CNT_W'(POST_CYCLES);
            end
        end else if (w_csr_in_d) begin
            if (w_pipe_occ) begin
                stall_f     = 1'b1;
                stall_d     = 1'b1;
                flush_e     = 1'b1;
                w_state_nxt = ST_DRAIN;
            end else begin
                w_state_nxt = ST_POST;
                w_cnt_nxt   = CNT_W'(POST_CYCLES);
            end
        end else if (w_load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else if (i_busy) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
        end
    end

    // Status outputs derived from registered state.
    always_comb begin
        discard_fetch = r_disc_pend & ~i_busy;
        serializing   = (r_state != ST_RUN);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed per-cycle vectors push their
// hand-computed outputs into a queue; a monitor pops and compares each cycle.
`timescale 1ns/1ps
module tb_hazard_ctrl;

    typedef struct packed {
        logic       i_busy;
        logic       d_busy;
        logic       ex_busy;
        logic       redirect;
        logic       trap;
        logic       d_valid;
        logic       d_is_csr;
        logic       d_use1;
        logic       d_use2;
        logic [4:0] d_ra1;
        logic [4:0] d_ra2;
        logic       e_valid;
        logic       e_is_load;
        logic [4:0] e_rd;
        logic       m_valid;
        logic       w_valid;
    } stim_t;

    typedef struct {
        string      name;
        logic [9:0] exp;
    } exp_t;

    // Expected-output bit positions.
    localparam logic [9:0] SF   = 10'b10_0000_0000;
    localparam logic [9:0] SD   = 10'b01_0000_0000;
    localparam logic [9:0] SE   = 10'b00_1000_0000;
    localparam logic [9:0] SM   = 10'b00_0100_0000;
    localparam logic [9:0] FD   = 10'b00_0010_0000;
    localparam logic [9:0] FE   = 10'b00_0001_0000;
    localparam logic [9:0] FM   = 10'b00_0000_1000;
    localparam logic [9:0] FW   = 10'b00_0000_0100;
    localparam logic [9:0] DISC = 10'b00_0000_0010;
    localparam logic [9:0] SER  = 10'b00_0000_0001;
    localparam logic [9:0] NONE = 10'b00_0000_0000;

    logic       clk;
    logic       rst_n;
    logic       i_busy, d_busy, ex_busy, redirect, trap;
    logic       d_valid, d_is_csr, d_use1, d_use2;
    logic [4:0] d_ra1, d_ra2;
    logic       e_valid, e_is_load;
    logic [4:0] e_rd;
    logic       m_valid, w_valid;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_m, flush_w;
    logic       discard_fetch, serializing;

    int checks   = 0;
    int failures = 0;
    exp_t sb_q[$];

    hazard_ctrl #(.POST_CYCLES(3)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .i_busy        (i_busy),
        .d_busy        (d_busy),
        .ex_busy       (ex_busy),
        .redirect      (redirect),
        .trap          (trap),
        .d_valid       (d_valid),
        .d_is_csr      (d_is_csr),
        .d_use1        (d_use1),
        .d_use2        (d_use2),
        .d_ra1         (d_ra1),
        .d_ra2         (d_ra2),
        .e_valid       (e_valid),
        .e_is_load     (e_is_load),
        .e_rd          (e_rd),
        .m_valid       (m_valid),
        .w_valid       (w_valid),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .stall_e       (stall_e),
        .stall_m       (stall_m),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .flush_m       (flush_m),
        .flush_w       (flush_w),
        .discard_fetch (discard_fetch),
        .serializing   (serializing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are valid every cycle; compare mid-cycle on negedge.
    always @(negedge clk) begin
        logic [9:0] act;
        exp_t       e;
        act = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
               flush_m, flush_w, discard_fetch, serializing};
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got %b expected %b (sf sd se sm fd fe fm fw disc ser)",
                         e.name, act, e.exp);
            end
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t csr(input logic e, input logic m, input logic w);
        stim_t s;
        s = '0;
        s.d_valid  = 1'b1;
        s.d_is_csr = 1'b1;
        s.e_valid  = e;
        s.m_valid  = m;
        s.w_valid  = w;
        return s;
    endfunction

    task automatic apply(input stim_t s, input logic rst);
        rst_n     = rst;
        i_busy    = s.i_busy;
        d_busy    = s.d_busy;
        ex_busy   = s.ex_busy;
        redirect  = s.redirect;
        trap      = s.trap;
        d_valid   = s.d_valid;
        d_is_csr  = s.d_is_csr;
        d_use1    = s.d_use1;
        d_use2    = s.d_use2;
        d_ra1     = s.d_ra1;
        d_ra2     = s.d_ra2;
        e_valid   = s.e_valid;
        e_is_load = s.e_is_load;
        e_rd      = s.e_rd;
        m_valid   = s.m_valid;
        w_valid   = s.w_valid;
    endtask

    // One cycle: drive just after the rising edge and queue the expectation.
    task automatic cyc(input stim_t s, input logic rst, input logic [9:0] exp, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        apply(s, rst);
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    initial begin
        stim_t s;
        exp_t  e0;

        apply(idle(), 1'b0);
        e0.name = "reset_idle";
        e0.exp  = NONE;
        sb_q.push_back(e0);
        cyc(idle(), 1'b1, NONE, "run_idle");

        // Load-use on rs1, then bubble in E, then x0 destination, then rs2 match.
        s = idle();
        s.d_valid = 1'b1; s.d_use1 = 1'b1; s.d_ra1 = 5'd5;
        s.e_valid = 1'b1; s.e_is_load = 1'b1; s.e_rd = 5'd5;
        cyc(s, 1'b1, SF | SD | FE, "load_use_rs1");
        s.e_valid = 1'b0;
        cyc(s, 1'b1, NONE, "load_use_bubble");
        s.e_valid = 1'b1; s.e_rd = 5'd0; s.d_ra1 = 5'd0;
        cyc(s, 1'b1, NONE, "load_use_x0");
        s = idle();
        s.d_valid = 1'b1; s.d_use2 = 1'b1; s.d_ra2 = 5'd17; s.d_ra1 = 5'd3;
        s.e_valid = 1'b1; s.e_is_load = 1'b1; s.e_rd = 5'd17;
        cyc(s, 1'b1, SF | SD | FE, "load_use_rs2");
        s.d_use2 = 1'b0;
        cyc(s, 1'b1, NONE, "load_use_unused_src");

        // CSR serialize: drain E/M/W one per cycle, issue, POST with an ex_busy gap.
        cyc(csr(1, 1, 1), 1'b1, SF | SD | FE,       "csr_run_to_drain");
        cyc(csr(0, 1, 1), 1'b1, SF | SD | FE | SER, "csr_drain_1");
        cyc(csr(0, 0, 1), 1'b1, SF | SD | FE | SER, "csr_drain_2");
        cyc(csr(0, 0, 0), 1'b1, SER,                "csr_issue");
        s = idle(); s.d_valid = 1'b1; s.e_valid = 1'b1;
        cyc(s, 1'b1, SF | SD | FE | SER, "csr_post_1");
        s.ex_busy = 1'b1;
        cyc(s, 1'b1, SF | SD | SE | FM | SER, "csr_post_exbusy_hold");
        s.ex_busy = 1'b0;
        cyc(s, 1'b1, SF | SD | FE | SER, "csr_post_2");
        cyc(s, 1'b1, SF | SD | FE | SER, "csr_post_3");
        cyc(s, 1'b1, NONE,               "csr_back_to_run");

        // Stale fetch: redirect while fetch outstanding, discard on return.
        s = idle(); s.redirect = 1'b1; s.i_busy = 1'b1;
        cyc(s, 1'b1, FD | FE, "stale_redirect");
        s = idle(); s.i_busy = 1'b1;
        for (int i = 0; i < 4; i++) cyc(s, 1'b1, SF | FD, "stale_ibusy_hold");
        cyc(idle(), 1'b1, DISC, "stale_discard");
        cyc(idle(), 1'b1, NONE, "stale_cleared");
        s = idle(); s.redirect = 1'b1; s.i_busy = 1'b1;
        cyc(s, 1'b1, FD | FE, "stale_redirect_a");
        cyc(s, 1'b1, FD | FE, "stale_redirect_b");
        s = idle(); s.i_busy = 1'b1;
        cyc(s, 1'b1, SF | FD, "stale_ibusy_2");
        cyc(idle(), 1'b1, DISC, "stale_single_discard");
        cyc(idle(), 1'b1, NONE, "stale_cleared_2");

        // Priority: d_busy beats everything while in DRAIN; state must hold.
        cyc(csr(1, 0, 0), 1'b1, SF | SD | FE, "prio_enter_drain");
        s = csr(1, 0, 0);
        s.d_busy = 1'b1; s.ex_busy = 1'b1; s.redirect = 1'b1; s.i_busy = 1'b1;
        s.e_is_load = 1'b1; s.e_rd = 5'd5; s.d_use1 = 1'b1; s.d_ra1 = 5'd5;
        cyc(s, 1'b1, SF | SD | SE | SM | FW | SER, "prio_dbusy_wins");
        cyc(csr(1, 0, 0), 1'b1, SF | SD | FE | SER, "prio_drain_held_no_disc");
        s = csr(1, 0, 0); s.ex_busy = 1'b1;
        cyc(s, 1'b1, SF | SD | SE | FM | SER, "prio_exbusy_in_drain");
        s = csr(1, 0, 0); s.redirect = 1'b1;
        cyc(s, 1'b1, FD | FE | SER, "redirect_kills_drain");
        cyc(idle(), 1'b1, NONE, "after_drain_kill");

        // Trap and d_busy together: trap wins.
        s = idle(); s.trap = 1'b1; s.d_busy = 1'b1;
        cyc(s, 1'b1, FD | FE | FM, "trap_beats_dbusy");
        cyc(idle(), 1'b1, NONE, "after_trap_dbusy");

        // Trap in POST with cnt=2, fetch in flight.
        cyc(csr(0, 0, 0), 1'b1, NONE, "csr_direct_issue");
        cyc(idle(), 1'b1, SF | SD | FE | SER, "post_cnt3");
        s = idle(); s.trap = 1'b1; s.i_busy = 1'b1;
        cyc(s, 1'b1, FD | FE | FM | SER, "trap_in_post");
        cyc(idle(), 1'b1, DISC, "after_trap_run_discard");
        cyc(idle(), 1'b1, NONE, "after_trap_idle");

        // Asynchronous reset in the middle of DRAIN.
        cyc(csr(1, 0, 0), 1'b1, SF | SD | FE,       "rst_enter_drain");
        cyc(csr(1, 0, 0), 1'b1, SF | SD | FE | SER, "rst_in_drain");
        cyc(csr(1, 0, 0), 1'b0, SF | SD | FE,       "rst_async_to_run");
        cyc(idle(),       1'b0, NONE,               "rst_held_idle");
        cyc(idle(),       1'b1, NONE,               "rst_released_idle");

        repeat (2) @(posedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
